// File: rtl/audio_codec_config_pkg.sv
// Shared types and constants for the WM8731 configuration sequencer:
// FSM states, codec register map and the init-table entry layout.
package audio_cfg_pkg;

  localparam int CLK_DIV_DEF = 125;
  localparam logic [6:0] DEV_ADDR = 7'h1A;
  localparam logic [7:0] ADDR_WR = {DEV_ADDR, 1'b0};
  localparam int NUM_INIT = 11;
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_ACK,
    S_STOP,
    S_GAP
  } state_t;

  // WM8731 register addresses
  localparam logic [6:0] R_LLIN   = 7'h00;
  localparam logic [6:0] R_RLIN   = 7'h01;
  localparam logic [6:0] R_LHP    = 7'h02;
  localparam logic [6:0] R_RHP    = 7'h03;
  localparam logic [6:0] R_APATH  = 7'h04;
  localparam logic [6:0] R_DPATH  = 7'h05;
  localparam logic [6:0] R_PWR    = 7'h06;
  localparam logic [6:0] R_DAIF   = 7'h07;
  localparam logic [6:0] R_SRATE  = 7'h08;
  localparam logic [6:0] R_ACTIVE = 7'h09;
  localparam logic [6:0] R_RESET  = 7'h0F;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } init_entry_t;

endpackage

// File: rtl/audio_codec_config_if.sv
// Host request handshake plus the open-drain I2C pin controls.
interface audio_codec_config_if;
  logic       req_valid;
  logic [6:0] req_addr;
  logic [8:0] req_data;
  logic       req_ready;
  logic       i2c_scl;
  logic       i2c_sda_oe;
  logic       i2c_sda_in;

  modport master (
    output req_valid, req_addr, req_data, i2c_sda_in,
    input  req_ready, i2c_scl, i2c_sda_oe
  );

  modport slave (
    input  req_valid, req_addr, req_data, i2c_sda_in,
    output req_ready, i2c_scl, i2c_sda_oe
  );
endinterface

// File: rtl/audio_codec_config_codec_reg_rom.sv
// Power-up register table for the WM8731, indexed combinationally.
module codec_reg_rom
  import audio_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  output init_entry_t      entry
);
  always_comb begin
    entry = '0;
    case (index)
      4'd0:    entry = '{addr: R_RESET,  data: 9'h000};
      4'd1:    entry = '{addr: R_PWR,    data: 9'h000};
      4'd2:    entry = '{addr: R_LLIN,   data: 9'h017};
      4'd3:    entry = '{addr: R_RLIN,   data: 9'h017};
      4'd4:    entry = '{addr: R_LHP,    data: 9'h079};
      4'd5:    entry = '{addr: R_RHP,    data: 9'h079};
      4'd6:    entry = '{addr: R_APATH,  data: 9'h012};
      4'd7:    entry = '{addr: R_DPATH,  data: 9'h000};
      4'd8:    entry = '{addr: R_DAIF,   data: 9'h042};
      4'd9:    entry = '{addr: R_SRATE,  data: 9'h000};
      4'd10:   entry = '{addr: R_ACTIVE, data: 9'h001};
      default: entry = '0;
    endcase
  end
endmodule

// File: rtl/audio_codec_config.sv
// I2C write sequencer for the WM8731: runs the init table on start or sends
// one host register write, each as a 3-byte frame with ACK checking.
//
// state | meaning
// IDLE  | bus released, waiting for start or req_valid
// LOAD  | latch next frame (table entry or host request)
// START | SDA low while SCL high for 2 phases
// DATA  | shift one byte out MSB first
// ACK   | release SDA, sample slave ACK at end of phase 2
// STOP  | SDA low, SCL rises, SDA released 2 phases later
// GAP   | one bit time of idle bus between frames
module audio_codec_config
  import audio_cfg_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic                 CLOCK_50,
  input  logic                 Reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 init_done,
  output logic                 nack_err,
  audio_codec_config_if.slave  bus
);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] PH_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INIT - 1);

  state_t           state;
  logic [CNT_W-1:0] ph_cnt;
  logic [1:0]       phase;
  logic             tc;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_cnt;
  logic [23:0]      frame;
  logic [IDX_W-1:0] index;
  logic             init_mode;
  logic             nack_q;
  logic [6:0]       req_addr_q;
  logic [8:0]       req_data_q;
  logic             scl_q;
  logic             oe_q;
  logic [1:0]       sda_sync;
  logic             accept;
  init_entry_t      rom_entry;

  codec_reg_rom u_rom (
    .index (index),
    .entry (rom_entry)
  );

  assign tc             = (ph_cnt == '0);
  assign accept         = (state == S_IDLE) && bus.req_valid && !start;
  // Gated by Reset so a held request cannot show ready while in reset.
  assign bus.req_ready  = Reset && accept;
  assign bus.i2c_scl    = scl_q;
  assign bus.i2c_sda_oe = oe_q;

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) sda_sync <= 2'b11;
    else        sda_sync <= {sda_sync[0], bus.i2c_sda_in};
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      ph_cnt     <= '0;
      phase      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      frame      <= '0;
      index      <= '0;
      init_mode  <= 1'b0;
      nack_q     <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      scl_q      <= 1'b1;
      oe_q       <= 1'b0;
      busy       <= 1'b0;
      init_done  <= 1'b0;
      nack_err   <= 1'b0;
    end else begin
      if (state != S_IDLE && state != S_LOAD) begin
        if (tc) begin
          ph_cnt <= PH_RELOAD;
          phase  <= phase + 2'd1;
        end else begin
          ph_cnt <= ph_cnt - 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          scl_q <= 1'b1;
          oe_q  <= 1'b0;
          if (start) begin
            index     <= '0;
            init_done <= 1'b0;
            nack_err  <= 1'b0;
            init_mode <= 1'b1;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end else if (accept) begin
            req_addr_q <= bus.req_addr;
            req_data_q <= bus.req_data;
            init_mode  <= 1'b0;
            busy       <= 1'b1;
            state      <= S_LOAD;
          end
        end

        S_LOAD: begin
          frame  <= init_mode ? {ADDR_WR, rom_entry.addr, rom_entry.data}
                              : {ADDR_WR, req_addr_q, req_data_q};
          nack_q <= 1'b0;
          ph_cnt <= PH_RELOAD;
          phase  <= '0;
          scl_q  <= 1'b1;
          oe_q   <= 1'b1;
          state  <= S_START;
        end

        S_START: begin
          if (tc && phase == 2'd1) begin
            phase    <= '0;
            scl_q    <= 1'b0;
            oe_q     <= ~frame[23];
            bit_cnt  <= 3'd7;
            byte_cnt <= 2'd2;
            state    <= S_DATA;
          end
        end

        S_DATA: begin
          if (tc && phase == 2'd1) scl_q <= 1'b1;
          if (tc && phase == 2'd3) begin
            scl_q <= 1'b0;
            frame <= {frame[22:0], 1'b0};
            if (bit_cnt == '0) begin
              oe_q  <= 1'b0;
              state <= S_ACK;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              oe_q    <= ~frame[22];
            end
          end
        end

        S_ACK: begin
          if (tc && phase == 2'd1) scl_q <= 1'b1;
          if (tc && phase == 2'd2) nack_q <= sda_sync[1];
          if (tc && phase == 2'd3) begin
            scl_q <= 1'b0;
            if (nack_q || byte_cnt == '0) begin
              nack_err <= nack_err | nack_q;
              oe_q     <= 1'b1;
              state    <= S_STOP;
            end else begin
              byte_cnt <= byte_cnt - 1'b1;
              bit_cnt  <= 3'd7;
              oe_q     <= ~frame[23];
              state    <= S_DATA;
            end
          end
        end

        S_STOP: begin
          if (tc && phase == 2'd1) scl_q <= 1'b1;
          if (tc && phase == 2'd3) begin
            oe_q  <= 1'b0;
            state <= S_GAP;
          end
        end

        S_GAP: begin
          if (tc && phase == 2'd3) begin
            if (init_mode && !nack_q && index != LAST_IDX) begin
              index <= index + 1'b1;
              state <= S_LOAD;
            end else begin
              if (init_mode && !nack_q) init_done <= 1'b1;
              init_mode <= 1'b0;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end

        default: begin
          scl_q <= 1'b1;
          oe_q  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_audio_codec_config.sv
// Bench for audio_codec_config: decodes the I2C pins into frames with an
// open-drain slave model and compares them with frames built from the table.
module tb_audio_codec_config;
  localparam int DIV     = 2;
  localparam int BIT_CYC = 4 * DIV;
  localparam int NINIT   = 11;

  typedef struct { int n; int b; } frm_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, init_done, nack_err;
  logic slave_low = 1'b0;

  audio_codec_config_if bus();
  assign bus.i2c_sda_in = ~bus.i2c_sda_oe & ~slave_low;

  audio_codec_config #(.CLK_DIV(DIV)) dut (
    .CLOCK_50  (clk),
    .Reset     (rst_n),
    .start     (start),
    .busy      (busy),
    .init_done (init_done),
    .nack_err  (nack_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int tab_reg[NINIT] = '{15, 6, 0, 1, 2, 3, 4, 5, 7, 8, 9};
  int tab_dat[NINIT] = '{'h000, 'h000, 'h017, 'h017, 'h079, 'h079, 'h012,
                         'h000, 'h042, 'h000, 'h001};

  int n_chk = 0;
  int n_err = 0;
  frm_t exp_q[$];
  frm_t obs_q[$];

  int nack_frame = -1;
  int nack_byte  = -1;
  int frm_idx    = -1;
  int rdy_cnt    = 0;
  int rise_total = 0;
  int nbits      = 0;
  bit active     = 0;

  task automatic chk(input string tag, input int got, input int expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Expected bus bytes for one register write, cut after a NACKed byte.
  task automatic push_exp(input int r, input int d, input int nbytes);
    frm_t f;
    int full;
    full = 'h34 * 65536 + ((r * 2 + d / 256) % 256) * 256 + (d % 256);
    f.n = nbytes;
    f.b = full >> (8 * (3 - nbytes));
    exp_q.push_back(f);
  endtask

  // Pin-level monitor and slave: START/STOP, bit capture, ACK drive.
  int  cyc = 0, last_rise = 0, bytebuf = 0, cur = 0, nb = 0;
  bit  have_rise = 0, prev_scl = 1, prev_sda = 1;
  always @(negedge clk) begin
    logic scl, line;
    cyc++;
    if (bus.req_ready === 1'b1) rdy_cnt++;
    if (!rst_n) begin
      active    = 0;
      nbits     = 0;
      have_rise = 0;
      prev_scl  = 1;
      prev_sda  = 1;
      slave_low = 1'b0;
    end else begin
      scl  = bus.i2c_scl;
      line = bus.i2c_sda_in;
      if (!prev_scl && scl) rise_total++;
      if (prev_scl && scl && line != prev_sda) begin
        if (!line) begin
          chk("start_outside_frame", int'(active), 0);
          active = 1; nbits = 0; cur = 0; nb = 0; bytebuf = 0; have_rise = 0;
          frm_idx++;
        end else begin
          chk("stop_after_ack", nbits % 9, 1);
          if (active) obs_q.push_back('{nb, cur});
          active = 0;
        end
      end else if (!prev_scl && scl && active) begin
        if (have_rise) chk("scl_period", cyc - last_rise, BIT_CYC);
        have_rise = 1;
        last_rise = cyc;
        if (nbits % 9 < 8) bytebuf = (bytebuf * 2 + int'(line)) % 256;
        else begin
          cur = cur * 256 + bytebuf;
          nb++;
        end
        nbits++;
      end else if (prev_scl && !scl && active) begin
        slave_low = (nbits % 9 == 8) &&
                    !(frm_idx == nack_frame && nbits / 9 == nack_byte);
      end
      prev_scl = scl;
      prev_sda = line;
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_in_time"}, int'(n < 6000), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic compare_frames(input string tag);
    int m;
    chk({tag, "_frame_count"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_f%0d_nbytes", tag, i), obs_q[i].n, exp_q[i].n);
      chk($sformatf("%s_f%0d_bytes", tag, i), obs_q[i].b, exp_q[i].b);
    end
    obs_q.delete();
    exp_q.delete();
    frm_idx = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_req(input int a, input int d, input string tag);
    int n = 0;
    @(negedge clk);
    bus.req_addr  = 7'(a);
    bus.req_data  = 9'(d);
    bus.req_valid = 1'b1;
    #1;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_accepted"}, int'(n < 200), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic push_init_all();
    for (int i = 0; i < NINIT; i++) push_exp(tab_reg[i], tab_dat[i], 3);
  endtask

  initial begin
    int r0, a, d, nk, n;
    bit exp_nack, exp_done;

    bus.req_valid = 1'b1;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", bus.i2c_scl, 1);
    chk("rst_oe", bus.i2c_sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_nack_err", nack_err, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Full init with every byte ACKed; oe asserts on the second edge.
    push_init_all();
    pulse_start();
    chk("start_oe_edge1", bus.i2c_sda_oe, 0);
    @(posedge clk); #1;
    chk("start_oe_edge2", bus.i2c_sda_oe, 1);
    chk("start_busy", busy, 1);
    wait_idle("init");
    compare_frames("init");
    chk("init_done_set", init_done, 1);
    chk("init_no_nack", nack_err, 0);
    exp_done = 1;
    exp_nack = 0;

    // Single host write, fixed values.
    r0 = rdy_cnt;
    nack_frame = -1;
    push_exp('h02, 'h07F, 3);
    send_req('h02, 'h07F, "req_fixed");
    chk("req_fixed_ready_cycles", rdy_cnt - r0, 1);
    wait_idle("req_fixed");
    compare_frames("req_fixed");
    chk("req_fixed_init_done", init_done, int'(exp_done));

    // Randomized host writes, some NACKed on a random byte.
    for (int k = 0; k < 8; k++) begin
      a  = $urandom_range(0, 127);
      d  = $urandom_range(0, 511);
      nk = int'($urandom_range(0, 5)) - 3;
      nack_frame = 0;
      nack_byte  = (nk < 0) ? -1 : nk;
      n = (nk < 0) ? 3 : nk + 1;
      if (nk >= 0) exp_nack = 1;
      push_exp(a, d, n);
      r0 = rdy_cnt;
      repeat ($urandom_range(0, 10)) @(posedge clk);
      send_req(a, d, "req_rand");
      chk("req_rand_ready_cycles", rdy_cnt - r0, 1);
      wait_idle("req_rand");
      compare_frames("req_rand");
      chk("req_rand_nack_err", nack_err, int'(exp_nack));
      chk("req_rand_init_done", init_done, int'(exp_done));
    end
    nack_frame = -1;
    nack_byte  = -1;

    // Init aborted by a NACK on byte 1 of frame 3.
    nack_frame = 3;
    nack_byte  = 1;
    for (int i = 0; i < 3; i++) push_exp(tab_reg[i], tab_dat[i], 3);
    push_exp(tab_reg[3], tab_dat[3], 2);
    pulse_start();
    wait_idle("init_nack");
    compare_frames("init_nack");
    chk("init_nack_err", nack_err, 1);
    chk("init_nack_done", init_done, 0);
    chk("init_nack_busy", busy, 0);
    nack_frame = -1;
    nack_byte  = -1;

    // start and req_valid together: start wins, request follows the init.
    push_init_all();
    push_exp('h55, 'h1A3, 3);
    @(negedge clk);
    start = 1'b1;
    bus.req_addr  = 7'h55;
    bus.req_data  = 9'h1A3;
    bus.req_valid = 1'b1;
    #1;
    chk("both_ready_low", bus.req_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    r0 = rdy_cnt;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 6000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("both_req_served", int'(n < 6000), 1);
    chk("both_ready_after_init", init_done, 1);
    chk("both_ready_idle", busy, 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_idle("both");
    chk("both_ready_cycles", rdy_cnt - r0, 1);
    compare_frames("both");
    chk("both_nack_err", nack_err, 0);

    // Reset in the middle of the second byte, then a clean restart.
    pulse_start();
    n = 0;
    while (nbits < 12 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midreset_reached", int'(n < 2000), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_scl", bus.i2c_scl, 1);
    chk("midreset_oe", bus.i2c_sda_oe, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_init_done", init_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    frm_idx = -1;
    r0 = rise_total;
    repeat (60) @(posedge clk);
    #1;
    chk("postreset_quiet_scl", rise_total - r0, 0);
    chk("postreset_busy", busy, 0);
    push_init_all();
    pulse_start();
    wait_idle("restart");
    compare_frames("restart");
    chk("restart_init_done", init_done, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
